// File: rtl/gate_truth_table_sequencer_pkg.sv
// rtl/gate_truth_table_sequencer_pkg.sv - shared state encoding and parameter defaults for the gate sequencer
package gate_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

  localparam int DEF_N_IN          = 2;
  localparam int DEF_SETTLE_CYCLES = 4;

endpackage

// File: rtl/gate_truth_table_sequencer_if.sv
// rtl/gate_truth_table_sequencer_if.sv - control, result and gate-drive signals of the gate sequencer
interface gate_truth_table_sequencer_if
  import gate_seq_pkg::*;
#(
  parameter int N_IN = DEF_N_IN
) ();

  logic                   start;
  logic [(1<<N_IN)-1:0]   expected;
  logic                   dut_y;
  logic [N_IN-1:0]        dut_in;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [(1<<N_IN)-1:0]   fail_vec;
  logic [N_IN:0]          fail_count;

  modport master (
    output start, expected, dut_y,
    input  dut_in, busy, done, pass, fail_vec, fail_count
  );

  modport slave (
    input  start, expected, dut_y,
    output dut_in, busy, done, pass, fail_vec, fail_count
  );

endinterface

// File: rtl/gate_truth_table_sequencer_timer.sv
// rtl/gate_truth_table_sequencer_timer.sv - loadable down-counter that times the settle window
module seq_settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// rtl/gate_truth_table_sequencer.sv - exhaustive truth-table sweep of a combinational gate
// SEQ_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module gate_truth_table_sequencer
  import gate_seq_pkg::*;
#(
  parameter int N_IN          = DEF_N_IN,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input logic                        clk,
  input logic                        rst_n,
  gate_truth_table_sequencer_if.slave bus
);

  localparam int              NV          = 1 << N_IN;
  localparam int              TW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0]   SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(NV - 1);
  localparam logic [N_IN:0]   COUNT_MAX   = (N_IN+1)'(NV);

  seq_state_t      state;
  logic [N_IN-1:0] idx;
  logic [NV-1:0]   exp_latched;
  logic [N_IN-1:0] dut_in_r;
  logic            busy_r;
  logic            done_r;
  logic            pass_r;
  logic [NV-1:0]   fail_vec_r;
  logic [N_IN:0]   fail_count_r;
  logic            timer_zero;
  logic            miss;

  seq_settle_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == APPLY),
    .value (SETTLE_LOAD),
    .zero  (timer_zero)
  );

  assign miss = bus.dut_y ^ exp_latched[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      exp_latched  <= '0;
      dut_in_r     <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      fail_vec_r   <= '0;
      fail_count_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          dut_in_r <= '0;
          if (bus.start) begin
            state        <= APPLY;
            idx          <= '0;
            exp_latched  <= bus.expected;
            busy_r       <= 1'b1;
            pass_r       <= 1'b0;
            fail_vec_r   <= '0;
            fail_count_r <= '0;
          end
        end
        APPLY: begin
          dut_in_r <= idx;
          state    <= SETTLE;
        end
        SETTLE: begin
          if (timer_zero) state <= SAMPLE;
        end
        SAMPLE: begin
          if (miss) begin
            fail_vec_r[idx] <= 1'b1;
            if (fail_count_r != COUNT_MAX) fail_count_r <= fail_count_r + 1'b1;
          end
`ifdef SEQ_STOP_ON_FAIL_EN
          if (miss || idx == LAST_IDX) begin
`else
          if (idx == LAST_IDX) begin
`endif
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= APPLY;
          end
        end
        DONE: begin
          // dut_in is kept here so the failing vector is visible alongside done
          done_r <= 1'b1;
          busy_r <= 1'b0;
          pass_r <= (fail_count_r == '0);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dut_in     = dut_in_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.pass       = pass_r;
  assign bus.fail_vec   = fail_vec_r;
  assign bus.fail_count = fail_count_r;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// tb/tb_gate_truth_table_sequencer.sv - directed bench for the gate sequencer driving an or_gate
module tb_gate_truth_table_sequencer;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  gate_truth_table_sequencer_if #(.N_IN(2)) bus ();

  gate_truth_table_sequencer #(.N_IN(2), .SETTLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // or_gate under test
  assign bus.dut_y = |bus.dut_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEQ_STOP_ON_FAIL_EN
  localparam int       AND_LAT   = 13;
  localparam bit [3:0] AND_VEC   = 4'b0010;
  localparam int       AND_CNT   = 1;
  localparam bit [1:0] AND_DUTIN = 2'b01;
`else
  localparam int       AND_LAT   = 25;
  localparam bit [3:0] AND_VEC   = 4'b0110;
  localparam int       AND_CNT   = 2;
  localparam bit [1:0] AND_DUTIN = 2'b11;
`endif

  // Pulses start so it is sampled at edge t; returns edges from t until done is seen.
  task automatic run_sweep(input logic [3:0] exp_tab, output int lat);
    @(negedge clk);
    bus.expected = exp_tab;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start: got %b want 1", bus.busy);
    end
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.done === 1'b1) break;
    end
  endtask

  task automatic test_reset;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.expected = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.dut_in, bus.busy, bus.done, bus.pass, bus.fail_vec, bus.fail_count} !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: dut_in=%b busy=%b done=%b pass=%b fail_vec=%b fail_count=%0d want all 0",
               bus.dut_in, bus.busy, bus.done, bus.pass, bus.fail_vec, bus.fail_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dut_in !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_no_start: busy=%b done=%b dut_in=%b want 0 0 00", bus.busy, bus.done, bus.dut_in);
    end
  endtask

  task automatic test_good_or;
    int lat;
    run_sweep(4'b1110, lat);
    vectors++;
    if (lat !== 25) begin
      miscompares++;
      $display("FAIL good_latency: got %0d want 25", lat);
    end
    vectors++;
    if (bus.pass !== 1'b1 || bus.fail_vec !== 4'b0000 || bus.fail_count !== 3'd0) begin
      miscompares++;
      $display("FAIL good_result: pass=%b fail_vec=%b fail_count=%0d want 1 0000 0", bus.pass, bus.fail_vec, bus.fail_count);
    end
    vectors++;
    if (bus.busy !== 1'b0 || bus.dut_in !== 2'b11) begin
      miscompares++;
      $display("FAIL good_at_done: busy=%b dut_in=%b want 0 11", bus.busy, bus.dut_in);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.done !== 1'b0 || bus.dut_in !== 2'b00 || bus.pass !== 1'b1) begin
      miscompares++;
      $display("FAIL good_after_done: done=%b dut_in=%b pass=%b want 0 00 1", bus.done, bus.dut_in, bus.pass);
    end
  endtask

  task automatic test_and_table;
    int lat;
    run_sweep(4'b1000, lat);
    vectors++;
    if (lat !== AND_LAT) begin
      miscompares++;
      $display("FAIL and_latency: got %0d want %0d", lat, AND_LAT);
    end
    vectors++;
    if (bus.pass !== 1'b0 || bus.fail_vec !== AND_VEC || bus.fail_count !== 3'(AND_CNT)) begin
      miscompares++;
      $display("FAIL and_result: pass=%b fail_vec=%b fail_count=%0d want 0 %b %0d",
               bus.pass, bus.fail_vec, bus.fail_count, AND_VEC, AND_CNT);
    end
    vectors++;
    if (bus.dut_in !== AND_DUTIN) begin
      miscompares++;
      $display("FAIL and_dut_in: got %b want %b", bus.dut_in, AND_DUTIN);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.fail_vec !== AND_VEC || bus.fail_count !== 3'(AND_CNT) || bus.pass !== 1'b0) begin
      miscompares++;
      $display("FAIL and_held: fail_vec=%b fail_count=%0d pass=%b want %b %0d 0",
               bus.fail_vec, bus.fail_count, bus.pass, AND_VEC, AND_CNT);
    end
  endtask

  task automatic test_busy_start;
    int dones;
    int first;
    @(negedge clk);
    bus.expected = 4'b1110;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0;
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        dones++;
        if (first == 0) first = n;
      end
      if (n == 4) begin
        bus.start    = 1'b1;
        bus.expected = 4'b0000;
      end
      if (n == 5) bus.start = 1'b0;
      if (n == 25) begin
        vectors++;
        if (bus.pass !== 1'b1 || bus.fail_vec !== 4'b0000 || bus.fail_count !== 3'd0) begin
          miscompares++;
          $display("FAIL busy_result: pass=%b fail_vec=%b fail_count=%0d want 1 0000 0", bus.pass, bus.fail_vec, bus.fail_count);
        end
      end
    end
    vectors++;
    if (dones !== 1 || first !== 25) begin
      miscompares++;
      $display("FAIL busy_start_ignored: dones=%0d first=%0d want 1 25", dones, first);
    end
  endtask

  task automatic test_back_to_back;
    int dones;
    int pos [2];
    @(negedge clk);
    bus.expected = 4'b1110;
    bus.start    = 1'b1;
    @(posedge clk);
    dones  = 0;
    pos[0] = 0;
    pos[1] = 0;
    for (int n = 1; n <= 70; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        if (dones < 2) pos[dones] = n;
        dones++;
      end
      if (n == 30) bus.start = 1'b0;
    end
    vectors++;
    if (dones !== 2 || pos[0] !== 25 || pos[1] !== 51) begin
      miscompares++;
      $display("FAIL back_to_back: dones=%0d at %0d,%0d want 2 at 25,51", dones, pos[0], pos[1]);
    end
  endtask

  task automatic test_mid_reset;
    int lat;
    int wait_n;
    int dones;
    @(negedge clk);
    bus.expected = 4'b1110;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_n = 0;
    while (bus.dut_in !== 2'b10 && wait_n < 100) begin
      @(posedge clk);
      wait_n++;
      #1;
    end
    vectors++;
    if (bus.dut_in !== 2'b10) begin
      miscompares++;
      $display("FAIL mid_reset_reach_v2: dut_in=%b want 10", bus.dut_in);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.dut_in !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.fail_count !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_reset_clear: dut_in=%b busy=%b done=%b fail_count=%0d want 00 0 0 0",
               bus.dut_in, bus.busy, bus.done, bus.fail_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
    end
    vectors++;
    if (dones !== 0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_no_done: dones=%0d busy=%b want 0 0", dones, bus.busy);
    end
    run_sweep(4'b1110, lat);
    vectors++;
    if (lat !== 25 || bus.pass !== 1'b1 || bus.fail_vec !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset_resweep: lat=%0d pass=%b fail_vec=%b want 25 1 0000", lat, bus.pass, bus.fail_vec);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_good_or();
    test_and_table();
    test_busy_start();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
